// File: rtl/srg_shift_ctrl.sv
// srg_shift_ctrl: serialises a parallel word into an 8-bit-style serial-in shift register and captures its Q.
// Ports:
//   Clk        rising-edge clock
//   RST        asynchronous reset, active-low
//   CLR        synchronous abort back to IDLE, no result
//   IN_VALID / IN_READY / IN_DATA   word handshake from the master
//   SER, SH_EN                       serial bit and shift enable to the register
//   Q                                parallel output of the register
//   OUT_VALID / OUT_DATA             one-cycle result of the captured Q
//   BUSY                             high in SHIFT or CAPTURE
//   BIT_CNT                          shifts completed in the current transfer
//   MISMATCH                         only with SRG_SHIFT_CTRL_CHECK_EN defined: captured Q differs from the sent word
module srg_shift_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     Clk,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [WIDTH-1:0]         IN_DATA,
    output logic                     SER,
    output logic                     SH_EN,
    input  logic [WIDTH-1:0]         Q,
    output logic                     OUT_VALID,
    output logic [WIDTH-1:0]         OUT_DATA,
    output logic                     BUSY,
`ifdef SRG_SHIFT_CTRL_CHECK_EN
    output logic                     MISMATCH,
`endif
    output logic [$clog2(WIDTH)-1:0] BIT_CNT
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;

    assign SH_EN    = state == SHIFT;
    assign SER      = SH_EN & (MSB_FIRST ? shadow[WIDTH-1] : shadow[0]);
    assign BUSY     = state != IDLE;
    assign IN_READY = (state == IDLE) & ~CLR;

    // BIT_CNT holds at WIDTH-1 on the last shift so it never leaves range; CAPTURE clears it.
    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            shadow    <= '0;
            BIT_CNT   <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (CLR) begin
                state   <= IDLE;
                BIT_CNT <= '0;
            end else begin
                case (state)
                    IDLE: if (IN_VALID) begin
                        shadow  <= IN_DATA;
                        BIT_CNT <= '0;
                        state   <= SHIFT;
                    end
                    SHIFT: begin
                        shadow <= MSB_FIRST ? shadow << 1 : shadow >> 1;
                        if (BIT_CNT == LAST) state <= CAPTURE;
                        else BIT_CNT <= BIT_CNT + 1'b1;
                    end
                    CAPTURE: begin
                        OUT_DATA  <= Q;
                        OUT_VALID <= 1'b1;
                        BIT_CNT   <= '0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SRG_SHIFT_CTRL_CHECK_EN
    logic [WIDTH-1:0] sent;
    logic [WIDTH-1:0] sent_rev;

    always_comb begin
        sent_rev = '0;
        for (int i = 0; i < WIDTH; i++) sent_rev[i] = sent[WIDTH-1-i];
    end

    // LSB-first delivery lands the word bit-reversed in Q.
    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            sent     <= '0;
            MISMATCH <= 1'b0;
        end else begin
            MISMATCH <= 1'b0;
            if (!CLR && state == IDLE && IN_VALID) sent <= IN_DATA;
            if (!CLR && state == CAPTURE) MISMATCH <= Q != (MSB_FIRST ? sent : sent_rev);
        end
    end
`endif
endmodule

// File: tb/tb_srg_shift_ctrl.sv
// tb_srg_shift_ctrl: directed self-checking bench for srg_shift_ctrl with behavioural shift-register models.
module tb_srg_shift_ctrl;
    logic       Clk = 1'b0, RST = 1'b0, CLR = 1'b0;
    logic       in_valid = 1'b0, in_valid_l = 1'b0;
    logic [7:0] in_data = '0, in_data_l = '0;
    logic       in_ready, ser, sh_en, out_valid, busy;
    logic       in_ready_l, ser_l, sh_en_l, out_valid_l, busy_l;
    logic [7:0] out_data, out_data_l;
    logic [7:0] q = '0, q_l = '0, stuck = '0;
    logic [7:0] seq;
    logic [2:0] bit_cnt, bit_cnt_l;
`ifdef SRG_SHIFT_CTRL_CHECK_EN
    logic       mismatch, mismatch_l;
`endif
    int checks = 0, failures = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (sh_en) q <= {q[6:0], ser};
        if (sh_en_l) q_l <= {q_l[6:0], ser_l};
    end

    srg_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .Clk(Clk), .RST(RST), .CLR(CLR), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_DATA(in_data), .SER(ser), .SH_EN(sh_en), .Q(q), .OUT_VALID(out_valid),
        .OUT_DATA(out_data), .BUSY(busy),
`ifdef SRG_SHIFT_CTRL_CHECK_EN
        .MISMATCH(mismatch),
`endif
        .BIT_CNT(bit_cnt)
    );

    srg_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .Clk(Clk), .RST(RST), .CLR(CLR), .IN_VALID(in_valid_l), .IN_READY(in_ready_l),
        .IN_DATA(in_data_l), .SER(ser_l), .SH_EN(sh_en_l), .Q(q_l | stuck), .OUT_VALID(out_valid_l),
        .OUT_DATA(out_data_l), .BUSY(busy_l),
`ifdef SRG_SHIFT_CTRL_CHECK_EN
        .MISMATCH(mismatch_l),
`endif
        .BIT_CNT(bit_cnt_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        RST = 1'b1;
        step();
        chk("rel_ready", in_ready, 1);
        chk("rel_cnt", bit_cnt, 0);
        chk("rel_out_data", out_data, 8'h00);
        chk("rel_sh_en", sh_en, 0);
        chk("rel_ready_l", in_ready_l, 1);

        // single word A5, MSB first
        seq = 8'b1010_0101;
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("a5_sh_en", sh_en, 1);
            chk("a5_ser", ser, seq[8-k]);
            chk("a5_cnt", bit_cnt, k - 1);
            chk("a5_ready", in_ready, 0);
            step();
        end
        chk("a5_cap_sh_en", sh_en, 0);
        chk("a5_cap_ser", ser, 0);
        chk("a5_cap_busy", busy, 1);
        chk("a5_cap_ov", out_valid, 0);
        step();
        chk("a5_ov", out_valid, 1);
        chk("a5_data", out_data, 8'hA5);
        chk("a5_idle_busy", busy, 0);
        chk("a5_idle_cnt", bit_cnt, 0);
`ifdef SRG_SHIFT_CTRL_CHECK_EN
        chk("a5_mismatch", mismatch, 0);
`endif
        step();
        chk("a5_ov_pulse", out_valid, 0);

        // back-to-back 3C then FF with IN_VALID held
        in_data = 8'h3C; in_valid = 1'b1;
        step();
        in_data = 8'hFF;
        for (int k = 1; k <= 9; k++) begin
            chk("b2b_ready", in_ready, 0);
            step();
        end
        chk("b2b_ov1", out_valid, 1);
        chk("b2b_data1", out_data, 8'h3C);
        chk("b2b_ready_ov", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("b2b_accept2", busy, 1);
        n = 1;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
        chk("b2b_gap", n, 10);
        chk("b2b_data2", out_data, 8'hFF);
        step();

        // busy hold: IN_DATA changes during SHIFT of 81
        in_data = 8'h81; in_valid = 1'b1;
        step();
        in_data = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            chk("hold_ready", in_ready, 0);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("hold_ov", out_valid, 1);
        chk("hold_data", out_data, 8'h81);
        step();
        chk("hold_no_accept", busy, 0);

        // abort at BIT_CNT=4 of 5A
        in_data = 8'h5A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("abort_cnt4", bit_cnt, 4);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_cnt", bit_cnt, 0);
        chk("abort_sh_en", sh_en, 0);
        chk("abort_ready", in_ready, 1);
        n = 0;
        repeat (12) begin
            if (out_valid) n++;
            step();
        end
        chk("abort_no_ov", n, 0);
        chk("abort_data_kept", out_data, 8'h81);
        CLR = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        #1;
        chk("clr_ready", in_ready, 0);
        step();
        CLR = 1'b0; in_valid = 1'b0;
        chk("clr_no_accept", busy, 0);
        step();

        // async reset mid-SHIFT of C3
        in_data = 8'hC3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_ser_pre", ser, 1);
        chk("mid_busy_pre", busy, 1);
        RST = 1'b0; in_valid = 1'b1;
        #1;
        chk("mid_sh_en", sh_en, 0);
        chk("mid_ser", ser, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ov", out_valid, 0);
        chk("mid_cnt", bit_cnt, 0);
        chk("mid_data", out_data, 8'h00);
        step();
        step();
        chk("mid_hold_busy", busy, 0);
        in_valid = 1'b0; RST = 1'b1;
        #1;
        chk("mid_rel_ready", in_ready, 1);
        chk("mid_rel_cnt", bit_cnt, 0);
        step();

        // LSB first, 01
        seq = 8'b1000_0000;
        in_data_l = 8'h01; in_valid_l = 1'b1;
        step();
        in_valid_l = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("lsb_sh_en", sh_en_l, 1);
            chk("lsb_ser", ser_l, seq[8-k]);
            chk("lsb_cnt", bit_cnt_l, k - 1);
            step();
        end
        step();
        chk("lsb_ov", out_valid_l, 1);
        chk("lsb_data", out_data_l, 8'h80);
        chk("lsb_busy", busy_l, 0);
`ifdef SRG_SHIFT_CTRL_CHECK_EN
        chk("lsb_mismatch", mismatch_l, 0);
`endif
        step();

        // stuck-at-1 on Q[0] of the LSB-first register
        stuck = 8'h01;
        in_valid_l = 1'b1;
        step();
        in_valid_l = 1'b0;
        repeat (9) step();
        chk("stuck_ov", out_valid_l, 1);
        chk("stuck_data", out_data_l, 8'h81);
`ifdef SRG_SHIFT_CTRL_CHECK_EN
        chk("stuck_mismatch", mismatch_l, 1);
`endif
        step();
        chk("stuck_ov_pulse", out_valid_l, 0);
`ifdef SRG_SHIFT_CTRL_CHECK_EN
        chk("stuck_mismatch_pulse", mismatch_l, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
